// File: rtl/cache_pkg.sv
// Shared widths, address-field geometry, the built-in address trace and
// counter helpers for the two-level tag-only cache model.
package cache_pkg;

  localparam int unsigned ADDR_W      = 11;
  localparam int unsigned COUNT_W     = 32;
  localparam int unsigned OFFSET_BITS = 2;
  localparam int unsigned TRACE_LEN   = 16;
  localparam int unsigned L1_LINES    = 8;
  localparam int unsigned L2_LINES    = 32;

  localparam int unsigned L1_INDEX_W = $clog2(L1_LINES);
  localparam int unsigned L1_TAG_W   = ADDR_W - OFFSET_BITS - L1_INDEX_W;
  localparam int unsigned L2_INDEX_W = $clog2(L2_LINES);
  localparam int unsigned L2_TAG_W   = ADDR_W - OFFSET_BITS - L2_INDEX_W;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    ACC_L1_HIT,
    ACC_L2_HIT,
    ACC_L2_MISS
  } access_e;

  localparam addr_t TRACE [TRACE_LEN] = '{
    11'h000, 11'h004, 11'h000, 11'h020, 11'h000, 11'h003, 11'h080, 11'h000,
    11'h7FC, 11'h7FC, 11'h100, 11'h104, 11'h020, 11'h004, 11'h7FF, 11'h100
  };

  function automatic count_t sat_inc(input count_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_if.sv
// Lookup/fill port between the access controller and one tag store.
interface cache_if #(parameter int unsigned ADDR_W = 11);
  logic [ADDR_W-1:0] addr;
  logic              fill;
  logic              hit;

  modport master (output addr, output fill, input hit);
  modport slave  (input addr, input fill, output hit);
endinterface

// File: rtl/direct_mapped_tag_cache.sv
// Direct-mapped tag store: combinational hit, fill at the clock edge,
// valid bits cleared by the asynchronous active-low reset.
module direct_mapped_tag_cache #(
  parameter int unsigned LINES       = 8,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned ADDR_W      = 11
) (
  input  logic    clk,
  input  logic    rst_n,
  cache_if.slave  lk
);

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = ADDR_W - OFFSET_BITS - INDEX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;

  assign idx    = lk.addr[OFFSET_BITS +: INDEX_W];
  assign tag    = lk.addr[ADDR_W-1 -: TAG_W];
  assign lk.hit = valid[idx] && (tags[idx] == tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (lk.fill) begin
      valid[idx] <= 1'b1;
    end
  end

  // Tag contents are don't-care while the matching valid bit is clear.
  always_ff @(posedge clk) begin
    if (lk.fill) begin
      tags[idx] <= tag;
    end
  end

endmodule

// File: rtl/top.sv
// Two-level cache hit/miss model: replays the built-in trace one address
// per cycle through L1 and L2 tag stores and keeps saturating counters.
module top
  import cache_pkg::*;
#(
  parameter int unsigned TRACE_LEN   = cache_pkg::TRACE_LEN,
  parameter int unsigned L1_LINES    = cache_pkg::L1_LINES,
  parameter int unsigned L2_LINES    = cache_pkg::L2_LINES,
  parameter int unsigned OFFSET_BITS = cache_pkg::OFFSET_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  address,
  output logic               hit_l1,
  output logic               hit_l2,
  output logic [COUNT_W-1:0] performance_counter_l1_hit,
  output logic [COUNT_W-1:0] performance_counter_l1_miss,
  output logic [COUNT_W-1:0] performance_counter_l2_hit,
  output logic [COUNT_W-1:0] performance_counter_l2_miss
);

  localparam int unsigned PTR_W = $clog2(TRACE_LEN);

  logic [PTR_W-1:0] ptr;
  access_e          access;

  cache_if #(.ADDR_W(ADDR_W)) l1_bus ();
  cache_if #(.ADDR_W(ADDR_W)) l2_bus ();

  assign address = TRACE[ptr];

  always_comb begin
    access = ACC_L2_MISS;
    if (l1_bus.hit) begin
      access = ACC_L1_HIT;
    end else if (l2_bus.hit) begin
      access = ACC_L2_HIT;
    end
  end

  assign hit_l1      = (access == ACC_L1_HIT);
  assign hit_l2      = (access == ACC_L2_HIT);
  assign l1_bus.addr = address;
  assign l2_bus.addr = address;
  assign l1_bus.fill = (access != ACC_L1_HIT);
  assign l2_bus.fill = (access == ACC_L2_MISS);

  direct_mapped_tag_cache #(
    .LINES      (L1_LINES),
    .OFFSET_BITS(OFFSET_BITS),
    .ADDR_W     (ADDR_W)
  ) u_l1 (
    .clk  (clk),
    .rst_n(rst_n),
    .lk   (l1_bus.slave)
  );

  direct_mapped_tag_cache #(
    .LINES      (L2_LINES),
    .OFFSET_BITS(OFFSET_BITS),
    .ADDR_W     (ADDR_W)
  ) u_l2 (
    .clk  (clk),
    .rst_n(rst_n),
    .lk   (l2_bus.slave)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr                         <= '0;
      performance_counter_l1_hit  <= '0;
      performance_counter_l1_miss <= '0;
      performance_counter_l2_hit  <= '0;
      performance_counter_l2_miss <= '0;
    end else begin
      ptr <= (ptr == PTR_W'(TRACE_LEN - 1)) ? '0 : ptr + 1'b1;
      unique case (access)
        ACC_L1_HIT: begin
          performance_counter_l1_hit <= sat_inc(performance_counter_l1_hit);
        end
        ACC_L2_HIT: begin
          performance_counter_l1_miss <= sat_inc(performance_counter_l1_miss);
          performance_counter_l2_hit  <= sat_inc(performance_counter_l2_hit);
        end
        default: begin
          performance_counter_l1_miss <= sat_inc(performance_counter_l1_miss);
          performance_counter_l2_miss <= sat_inc(performance_counter_l2_miss);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for the two-level cache model: hand-derived per-entry
// hit pattern and counter totals for the built-in trace.
module tb_top;
  logic        clk;
  logic        rst_n;
  logic [10:0] address;
  logic        hit_l1, hit_l2;
  logic [31:0] l1h, l1m, l2h, l2m;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  logic [10:0] exp_addr [16];
  logic [15:0] l1_hit_mask;
  logic [15:0] l2_hit_mask;
  logic [31:0] accesses;

  top dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .address                    (address),
    .hit_l1                     (hit_l1),
    .hit_l2                     (hit_l2),
    .performance_counter_l1_hit (l1h),
    .performance_counter_l1_miss(l1m),
    .performance_counter_l2_hit (l2h),
    .performance_counter_l2_miss(l2m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    chk({tag, "_l1_hit"},  l1h, a);
    chk({tag, "_l1_miss"}, l1m, b);
    chk({tag, "_l2_hit"},  l2h, c);
    chk({tag, "_l2_miss"}, l2m, d);
  endtask

  // One full trace pass from a cold cache, checking every entry.
  task automatic run_pass(input string tag);
    logic [31:0] e1h, e1m, e2h, e2m;
    e1h = 0; e1m = 0; e2h = 0; e2m = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {21'd0, address}, {21'd0, exp_addr[i]});
      chk($sformatf("%s_hl1_%0d", tag, i), {31'd0, hit_l1}, {31'd0, l1_hit_mask[i]});
      chk($sformatf("%s_hl2_%0d", tag, i), {31'd0, hit_l2}, {31'd0, l2_hit_mask[i]});
      if (l1_hit_mask[i]) e1h++;
      else begin
        e1m++;
        if (l2_hit_mask[i]) e2h++;
        else e2m++;
      end
      edge_step();
      chk_counts($sformatf("%s_cnt%0d", tag, i), e1h, e1m, e2h, e2m);
    end
    chk_counts({tag, "_total"}, 32'd4, 32'd12, 32'd3, 32'd9);
  endtask

  initial begin
    exp_addr = '{11'h000, 11'h004, 11'h000, 11'h020, 11'h000, 11'h003, 11'h080, 11'h000,
                 11'h7FC, 11'h7FC, 11'h100, 11'h104, 11'h020, 11'h004, 11'h7FF, 11'h100};
    l1_hit_mask = 16'h4224;  // entries 2, 5, 9, 14
    l2_hit_mask = 16'h9010;  // entries 4, 12, 15

    rst_n = 1'b0;
    edge_step();
    edge_step();
    chk("rst_addr", {21'd0, address}, 32'h000);
    chk("rst_hl1", {31'd0, hit_l1}, 32'd0);
    chk("rst_hl2", {31'd0, hit_l2}, 32'd0);
    chk_counts("rst", 32'd0, 32'd0, 32'd0, 32'd0);

    rst_n = 1'b1;
    run_pass("pass1");

    // Entry 16 wraps to 000; L1 set 0 holds tag 8 and L2 set 0 holds tag 2.
    chk("wrap_addr", {21'd0, address}, 32'h000);
    chk("wrap_hl1", {31'd0, hit_l1}, 32'd0);
    chk("wrap_hl2", {31'd0, hit_l2}, 32'd0);

    accesses = 16;
    for (int c = 0; c < 100; c++) begin
      edge_step();
      accesses++;
      chk($sformatf("inv_l2_%0d", c), l2h + l2m, l1m);
      chk($sformatf("inv_acc_%0d", c), l1h + l1m, accesses);
    end

    rst_n = 1'b0;
    #1;
    chk_counts("rst2", 32'd0, 32'd0, 32'd0, 32'd0);
    edge_step();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) edge_step();
    chk("pre_mid_addr", {21'd0, address}, 32'h7FC);
    chk("pre_mid_hl1", {31'd0, hit_l1}, 32'd1);
    chk_counts("pre_mid", 32'd2, 32'd7, 32'd1, 32'd6);

    #3;
    rst_n = 1'b0;
    #1;
    chk_counts("mid_rst", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("mid_rst_addr", {21'd0, address}, 32'h000);
    chk("mid_rst_hl1", {31'd0, hit_l1}, 32'd0);
    chk("mid_rst_hl2", {31'd0, hit_l2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_pass("replay");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
